pkt_decoder_gen: RTL and testbench
==================================

PKT_DECODER_GEN -- requirements
Module: pkt_decoder_gen

Interface
REQ-001 SHALL provide parameter DEV_ADDR, default 7'h15: device address matched in token byte 2 bits [6:0].
REQ-002 SHALL provide parameter CHUNK_BYTES, default 64: payload bytes per chunk.
REQ-003 SHALL provide parameter NUM_CHUNKS, default 2: chunks per frame; TOTAL = CHUNK_BYTES*NUM_CHUNKS bytes.
REQ-004 SHALL provide port clk, input, 1: sole clock, rising edge.
REQ-005 SHALL provide port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL provide port write_enable, input, 1: rx_data valid this cycle; held 2 cycles per byte, each assertion counts once (rising edge detected).
REQ-007 SHALL provide port rx_data, input, 8: received byte.
REQ-008 SHALL provide port eop, input, 1: end of packet, level, any length >= 1 cycle.
REQ-009 SHALL provide port rcv_error, input, 1: receiver error.
REQ-010 SHALL provide port frame_ack, input, 1: consumer releases frame.
REQ-011 SHALL provide port frame_data, output, TOTAL*8: frame, first payload byte in MSBs.
REQ-012 SHALL provide port frame_len, output, $clog2(TOTAL+1): valid byte count.
REQ-013 SHALL provide port frame_valid, output, 1: frame complete, held until frame_ack.
REQ-014 SHALL provide ports chunk_done, output, NUM_CHUNKS: bit i pulses 1 cycle when byte count crosses (i+1)*CHUNK_BYTES.
REQ-015 SHALL provide ports in_request, transmit_ack, interrupt, p_error, outputs, 1 each: single-cycle pulses.

Function
REQ-016 SHALL use states IDLE, TOK_ADDR, TOK_CRC, TOK_EOP, WAIT_DATA, DATA_META, DATA_PAYLOAD, DRAIN.
REQ-017 IDLE: byte 8'h69 (IN) or 8'hE1 (OUT) -> TOK_ADDR; other byte -> DRAIN, no error.
REQ-018 TOK_ADDR: record addr match (rx_data[6:0]==DEV_ADDR) -> TOK_CRC; next byte (ignored) -> TOK_EOP.
REQ-019 TOK_EOP on eop: IN+match -> in_request pulse, IDLE; OUT+match -> WAIT_DATA; mismatch -> IDLE silently.
REQ-020 WAIT_DATA: 8'hC3 (DATA0) or 8'h4B (DATA1) -> DATA_META; other byte -> p_error, DRAIN.
REQ-021 DATA_META: 8'h01 HASH_START, 8'h02 HASH_CONT, 8'h03 HASH_END, 8'h04 INTERRUPT -> DATA_PAYLOAD; other -> p_error, DRAIN.
REQ-022 DATA_PAYLOAD SHALL hold the two most recent bytes in a 2-byte delay line; a byte commits to the frame only when a third byte arrives; the two held at eop are CRC, discarded.
REQ-023 HASH_START SHALL zero frame_len at packet start; committed bytes write at index frame_len, frame_len+1 per commit.
REQ-024 Snapshot frame_len at DATA_META; on any discard, frame_len SHALL restore to snapshot.
REQ-025 Data toggle: expected PID resets to DATA0, flips on each accepted packet; mismatch -> payload discarded, transmit_ack still pulsed, toggle unchanged.
REQ-026 Accepted packet at eop: transmit_ack pulse; HASH_END -> frame_valid=1; INTERRUPT -> interrupt pulse, payload ignored.
REQ-027 Fewer than 2 bytes after meta at eop -> p_error, discard.
REQ-028 Commit with frame_len==TOTAL -> overflow; at eop p_error, discard, frame_len=0.
REQ-029 Hash packet while frame_valid=1 -> discard, no transmit_ack, toggle unchanged (host retries); INTERRUPT still accepted.
REQ-030 frame_ack while frame_valid -> frame_valid=0, frame_len=0 next cycle; frame_ack same cycle as HASH_END eop -> frame_valid set (set wins).
REQ-031 rcv_error any state -> DRAIN, discard, p_error pulse once; DRAIN exits to IDLE on eop.
REQ-032 eop in TOK_ADDR/TOK_CRC/WAIT_DATA/DATA_META -> p_error, IDLE; eop in IDLE ignored.
REQ-033 Pulses SHALL appear exactly 1 cycle after the eop/byte edge causing them.

Reset
REQ-034 On rst: state IDLE, toggle DATA0, frame_data 0, frame_len 0, all outputs 0, delay line cleared; mid-packet reset abandons packet, no pulses.

Verification
REQ-035 OUT addr 7'h15, DATA0, meta 8'h04, 2 CRC, eop -> transmit_ack and interrupt pulse, frame_len 0.
REQ-036 OUT, DATA0 meta 01 + 63 bytes + 2 CRC; OUT, DATA1 meta 03 + 49 bytes + 2 CRC -> frame_valid, frame_len 112, chunk_done[0] once, MSB byte = first payload byte.
REQ-037 Repeat previous DATA0 packet after acceptance -> transmit_ack, frame_len unchanged, toggle still DATA1.
REQ-038 OUT addr 7'h16 then DATA0 -> no transmit_ack, no state change; IN addr 7'h15 -> in_request pulse.
REQ-039 rcv_error mid-payload after 10 bytes -> p_error once, frame_len = snapshot, next valid packet accepted.
REQ-040 TOTAL+1 payload bytes in one HASH_START packet -> p_error at eop, frame_len 0, frame_valid 0.

Source files
------------

// File: rtl/pkt_decoder_gen.sv
// pkt_decoder_gen: token/data packet decoder that assembles hashed payload
// into a frame buffer.
//   clk, rst       : clock (rising edge), asynchronous active-high reset
//   write_enable   : byte strobe; held for two cycles per byte, rising edge counts
//   rx_data        : received byte
//   eop            : end-of-packet level; its rising edge is acted on
//   rcv_error      : receiver error; the packet is abandoned
//   frame_ack      : consumer releases a completed frame
//   frame_data     : assembled frame; first payload byte in the MSBs
//   frame_len      : number of valid bytes in frame_data
//   frame_valid    : frame complete, held until frame_ack
//   chunk_done     : bit i pulses when frame_len reaches (i+1)*CHUNK_BYTES
//   in_request, transmit_ack, interrupt, p_error : single-cycle pulses
module pkt_decoder_gen #(
  parameter logic [6:0]  DEV_ADDR    = 7'h15,
  parameter int unsigned CHUNK_BYTES = 64,
  parameter int unsigned NUM_CHUNKS  = 2,
  localparam int unsigned TOTAL      = CHUNK_BYTES * NUM_CHUNKS,
  localparam int unsigned LEN_W      = $clog2(TOTAL + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  write_enable,
  input  logic [7:0]            rx_data,
  input  logic                  eop,
  input  logic                  rcv_error,
  input  logic                  frame_ack,
  output logic [TOTAL*8-1:0]    frame_data,
  output logic [LEN_W-1:0]      frame_len,
  output logic                  frame_valid,
  output logic [NUM_CHUNKS-1:0] chunk_done,
  output logic                  in_request,
  output logic                  transmit_ack,
  output logic                  interrupt,
  output logic                  p_error
);

  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;

  typedef enum logic [2:0] {
    IDLE, TOK_ADDR, TOK_CRC, TOK_EOP, WAIT_DATA, DATA_META, DATA_PAYLOAD, DRAIN
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, eop_q, err_q;
  logic                  is_in_q, is_in_d;
  logic                  match_q, match_d;
  logic                  tog_q, tog_d;          // 1: DATA1 expected next
  logic                  pid1_q, pid1_d;
  logic                  pid_ok_q, pid_ok_d;
  logic                  busy_q, busy_d;        // hash packet while frame held
  logic                  is_int_q, is_int_d;
  logic                  is_end_q, is_end_d;
  logic                  live_q, live_d;        // payload commits to the frame
  logic                  ovf_q, ovf_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [7:0]            d0_q, d0_d, d1_q, d1_d;
  logic [LEN_W-1:0]      snap_q, snap_d;
  logic [TOTAL*8-1:0]    frame_data_q, frame_data_d;
  logic [LEN_W-1:0]      frame_len_q, frame_len_d;
  logic                  frame_valid_q, frame_valid_d;
  logic [NUM_CHUNKS-1:0] chunk_done_q, chunk_done_d;
  logic                  in_request_q, in_request_d;
  logic                  transmit_ack_q, transmit_ack_d;
  logic                  interrupt_q, interrupt_d;
  logic                  p_error_q, p_error_d;
  logic                  byte_evt, eop_evt, err_evt;

  assign byte_evt = write_enable & ~we_q;
  assign eop_evt  = eop & ~eop_q;
  assign err_evt  = rcv_error & ~err_q;

  always_comb begin
    state_d        = state_q;
    is_in_d        = is_in_q;
    match_d        = match_q;
    tog_d          = tog_q;
    pid1_d         = pid1_q;
    pid_ok_d       = pid_ok_q;
    busy_d         = busy_q;
    is_int_d       = is_int_q;
    is_end_d       = is_end_q;
    live_d         = live_q;
    ovf_d          = ovf_q;
    cnt_d          = cnt_q;
    d0_d           = d0_q;
    d1_d           = d1_q;
    snap_d         = snap_q;
    frame_data_d   = frame_data_q;
    frame_len_d    = frame_len_q;
    frame_valid_d  = frame_valid_q;
    chunk_done_d   = '0;
    in_request_d   = 1'b0;
    transmit_ack_d = 1'b0;
    interrupt_d    = 1'b0;
    p_error_d      = 1'b0;

    // Release is applied first so a HASH_END completing this cycle re-sets it.
    if (frame_ack && frame_valid_q) begin
      frame_valid_d = 1'b0;
      frame_len_d   = '0;
    end

    if (err_evt && state_q != DRAIN) begin
      p_error_d = 1'b1;
      state_d   = DRAIN;
      if (state_q == DATA_PAYLOAD && live_q) frame_len_d = snap_q;
    end else begin
      unique case (state_q)
        IDLE: if (byte_evt) begin
          if (rx_data == PID_IN || rx_data == PID_OUT) begin
            is_in_d = (rx_data == PID_IN);
            state_d = TOK_ADDR;
          end else begin
            state_d = DRAIN;
          end
        end
        TOK_ADDR: if (eop_evt) begin
          p_error_d = 1'b1;
          state_d   = IDLE;
        end else if (byte_evt) begin
          match_d = (rx_data[6:0] == DEV_ADDR);
          state_d = TOK_CRC;
        end
        TOK_CRC: if (eop_evt) begin
          p_error_d = 1'b1;
          state_d   = IDLE;
        end else if (byte_evt) begin
          state_d = TOK_EOP;
        end
        TOK_EOP: if (eop_evt) begin
          state_d = IDLE;
          if (match_q) begin
            if (is_in_q) in_request_d = 1'b1;
            else         state_d      = WAIT_DATA;
          end
        end
        WAIT_DATA: if (eop_evt) begin
          p_error_d = 1'b1;
          state_d   = IDLE;
        end else if (byte_evt) begin
          if (rx_data == PID_DATA0 || rx_data == PID_DATA1) begin
            pid1_d  = (rx_data == PID_DATA1);
            state_d = DATA_META;
          end else begin
            p_error_d = 1'b1;
            state_d   = DRAIN;
          end
        end
        DATA_META: if (eop_evt) begin
          p_error_d = 1'b1;
          state_d   = IDLE;
        end else if (byte_evt) begin
          if (rx_data >= 8'h01 && rx_data <= 8'h04) begin
            is_int_d = (rx_data == 8'h04);
            is_end_d = (rx_data == 8'h03);
            pid_ok_d = (pid1_q == tog_q);
            busy_d   = (rx_data != 8'h04) && frame_valid_d;
            live_d   = (rx_data != 8'h04) && (pid1_q == tog_q) && !frame_valid_d;
            snap_d   = frame_len_d;
            if (rx_data == 8'h01 && (pid1_q == tog_q) && !frame_valid_d)
              frame_len_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            d0_d    = '0;
            d1_d    = '0;
            state_d = DATA_PAYLOAD;
          end else begin
            p_error_d = 1'b1;
            state_d   = DRAIN;
          end
        end
        DATA_PAYLOAD: if (eop_evt) begin
          state_d = IDLE;
          if (cnt_q != 2'd2) begin
            p_error_d = 1'b1;
            if (live_q) frame_len_d = snap_q;
          end else if (busy_q) begin
            // Frame still held: host will retry, so no acknowledge.
          end else if (!pid_ok_q) begin
            transmit_ack_d = 1'b1;
          end else if (ovf_q) begin
            p_error_d   = 1'b1;
            frame_len_d = '0;
          end else begin
            transmit_ack_d = 1'b1;
            tog_d          = ~tog_q;
            if (is_end_q) frame_valid_d = 1'b1;
            if (is_int_q) interrupt_d   = 1'b1;
          end
        end else if (byte_evt) begin
          // Two-byte delay line: the oldest byte commits once a newer pair
          // exists, so the trailing CRC pair never reaches the frame.
          d1_d = d0_q;
          d0_d = rx_data;
          if (cnt_q != 2'd2) begin
            cnt_d = cnt_q + 2'd1;
          end else if (live_q) begin
            if (frame_len_q == LEN_W'(TOTAL)) begin
              ovf_d = 1'b1;
            end else begin
              for (int unsigned i = 0; i < TOTAL; i++)
                if (LEN_W'(i) == frame_len_q) frame_data_d[(TOTAL-1-i)*8 +: 8] = d1_q;
              frame_len_d = frame_len_q + LEN_W'(1);
              for (int unsigned i = 0; i < NUM_CHUNKS; i++)
                if (32'(frame_len_q) + 32'd1 == (i + 1) * CHUNK_BYTES) chunk_done_d[i] = 1'b1;
            end
          end
        end
        DRAIN: if (eop_evt) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      we_q           <= 1'b0;
      eop_q          <= 1'b0;
      err_q          <= 1'b0;
      is_in_q        <= 1'b0;
      match_q        <= 1'b0;
      tog_q          <= 1'b0;
      pid1_q         <= 1'b0;
      pid_ok_q       <= 1'b0;
      busy_q         <= 1'b0;
      is_int_q       <= 1'b0;
      is_end_q       <= 1'b0;
      live_q         <= 1'b0;
      ovf_q          <= 1'b0;
      cnt_q          <= '0;
      d0_q           <= '0;
      d1_q           <= '0;
      snap_q         <= '0;
      frame_data_q   <= '0;
      frame_len_q    <= '0;
      frame_valid_q  <= 1'b0;
      chunk_done_q   <= '0;
      in_request_q   <= 1'b0;
      transmit_ack_q <= 1'b0;
      interrupt_q    <= 1'b0;
      p_error_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      we_q           <= write_enable;
      eop_q          <= eop;
      err_q          <= rcv_error;
      is_in_q        <= is_in_d;
      match_q        <= match_d;
      tog_q          <= tog_d;
      pid1_q         <= pid1_d;
      pid_ok_q       <= pid_ok_d;
      busy_q         <= busy_d;
      is_int_q       <= is_int_d;
      is_end_q       <= is_end_d;
      live_q         <= live_d;
      ovf_q          <= ovf_d;
      cnt_q          <= cnt_d;
      d0_q           <= d0_d;
      d1_q           <= d1_d;
      snap_q         <= snap_d;
      frame_data_q   <= frame_data_d;
      frame_len_q    <= frame_len_d;
      frame_valid_q  <= frame_valid_d;
      chunk_done_q   <= chunk_done_d;
      in_request_q   <= in_request_d;
      transmit_ack_q <= transmit_ack_d;
      interrupt_q    <= interrupt_d;
      p_error_q      <= p_error_d;
    end
  end

  assign frame_data   = frame_data_q;
  assign frame_len    = frame_len_q;
  assign frame_valid  = frame_valid_q;
  assign chunk_done   = chunk_done_q;
  assign in_request   = in_request_q;
  assign transmit_ack = transmit_ack_q;
  assign interrupt    = interrupt_q;
  assign p_error      = p_error_q;

endmodule

// File: tb/tb_pkt_decoder_gen.sv
// Bench for pkt_decoder_gen: scoreboard of expected pulse events plus a
// packet-level reference model of frame contents, length, toggle and chunks.
module tb_pkt_decoder_gen;
  localparam int CHUNK = 64;
  localparam int NC    = 2;
  localparam int TOTAL = CHUNK * NC;
  localparam int LEN_W = $clog2(TOTAL + 1);
  localparam logic [3:0] P_INREQ = 4'b1000, P_ACK = 4'b0100, P_INT = 4'b0010, P_ERR = 4'b0001;

  logic clk = 0, rst = 0, write_enable = 0, eop = 0, rcv_error = 0, frame_ack = 0;
  logic [7:0] rx_data = 0;
  logic [TOTAL*8-1:0] frame_data;
  logic [LEN_W-1:0] frame_len;
  logic frame_valid, in_request, transmit_ack, interrupt, p_error;
  logic [NC-1:0] chunk_done;

  pkt_decoder_gen #(.DEV_ADDR(7'h15), .CHUNK_BYTES(CHUNK), .NUM_CHUNKS(NC)) dut (
    .clk(clk), .rst(rst), .write_enable(write_enable), .rx_data(rx_data), .eop(eop),
    .rcv_error(rcv_error), .frame_ack(frame_ack), .frame_data(frame_data),
    .frame_len(frame_len), .frame_valid(frame_valid), .chunk_done(chunk_done),
    .in_request(in_request), .transmit_ack(transmit_ack), .interrupt(interrupt),
    .p_error(p_error));

  always #5 clk = ~clk;

  typedef struct { logic [3:0] p; int len; bit valid; logic [7:0] data [TOTAL]; } exp_t;
  exp_t exp_q[$];
  int checks = 0, errors = 0;

  // reference model
  int m_len; bit m_valid; bit m_tog;
  logic [7:0] m_frame [TOTAL];
  int m_chunk [NC];
  int mon_chunk [NC];
  logic [7:0] pl[$];

  function automatic logic [7:0] cur_pid();
    return m_tog ? 8'h4B : 8'hC3;
  endfunction

  task automatic check(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [3:0] p);
    exp_t e;
    e.p = p; e.len = m_len; e.valid = m_valid;
    for (int k = 0; k < TOTAL; k++) e.data[k] = m_frame[k];
    exp_q.push_back(e);
  endtask

  // monitor / scoreboard
  exp_t me;
  logic [3:0] pv;
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NC; i++) if (chunk_done[i]) mon_chunk[i]++;
      pv = {in_request, transmit_ack, interrupt, p_error};
      if (pv != 4'b0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pulse: got %b expected none", pv);
        end else begin
          int bad;
          me = exp_q.pop_front();
          check("pulses", pv, me.p);
          check("event_len", frame_len, me.len);
          check("event_valid", frame_valid, me.valid);
          if (me.p[2]) begin
            bad = -1;
            for (int k = 0; k < me.len; k++)
              if (bad < 0 && frame_data[(TOTAL-1-k)*8 +: 8] != me.data[k]) bad = k;
            check("frame_data_first_bad_byte", bad, -1);
          end
        end
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; write_enable = 1; tick(); tick();
    write_enable = 0; tick();
  endtask

  task automatic send_eop(input bit ack);
    eop = 1; frame_ack = ack; tick();
    frame_ack = 0; tick();
    eop = 0; repeat (3) tick();
  endtask

  task automatic check_state(input string tag);
    check({tag, "_len"}, frame_len, m_len);
    check({tag, "_valid"}, frame_valid, m_valid);
  endtask

  task automatic do_reset();
    rst = 1; repeat (3) tick(); rst = 0; tick();
    m_len = 0; m_valid = 0; m_tog = 0;
    for (int k = 0; k < TOTAL; k++) m_frame[k] = 0;
  endtask

  task automatic do_ack();
    frame_ack = 1; tick(); frame_ack = 0; tick();
    if (m_valid) begin m_valid = 0; m_len = 0; end
    check_state("ack");
  endtask

  task automatic send_token(input logic [7:0] pid, input logic [6:0] addr);
    send_byte(pid); send_byte({1'b0, addr}); send_byte(8'($urandom));
    if (pid == 8'h69 && addr == 7'h15) push_exp(P_INREQ);
    send_eop(0);
  endtask

  // Writes committed payload into the model frame and counts chunk crossings.
  task automatic model_commit(input int s, input int n);
    for (int j = 0; j < n && s + j < TOTAL; j++) begin
      m_frame[s + j] = pl[j];
      for (int i = 0; i < NC; i++) if (s + j + 1 == (i + 1) * CHUNK) m_chunk[i]++;
    end
  endtask

  // nb = bytes after meta (payload + 2 CRC); err_after >= 0 raises rcv_error
  // after that many bytes.
  task automatic send_data(input logic [7:0] pid, input logic [7:0] meta, input int nb,
                           input int err_after, input bit ack_eop);
    bit hash, pid_ok, busy, live;
    int s, got;
    hash = (meta != 8'h04);
    pid_ok = (pid == cur_pid());
    busy = hash && m_valid;
    live = hash && pid_ok && !busy;
    s = (meta == 8'h01) ? 0 : m_len;
    pl.delete();
    for (int j = 0; j < nb; j++) pl.push_back(8'($urandom));
    send_byte(pid); send_byte(meta);
    got = (err_after >= 0 && err_after < nb) ? err_after : nb;
    for (int k = 0; k < got; k++) send_byte(pl[k]);
    if (live && got > 2) model_commit(s, got - 2);
    if (got < nb) begin
      push_exp(P_ERR);
      rcv_error = 1; tick(); rcv_error = 0; tick();
      send_eop(0);
    end else begin
      if (nb < 2) push_exp(P_ERR);
      else if (busy) ;
      else if (!pid_ok) push_exp(P_ACK);
      else if (hash && nb - 2 > TOTAL - s) begin m_len = 0; push_exp(P_ERR); end
      else begin
        m_tog = ~m_tog;
        if (hash) m_len = s + nb - 2;
        if (meta == 8'h03) m_valid = 1;
        push_exp(meta == 8'h04 ? (P_ACK | P_INT) : P_ACK);
      end
      send_eop(ack_eop);
    end
    check_state("pkt");
  endtask

  initial begin
    for (int i = 0; i < NC; i++) begin m_chunk[i] = 0; mon_chunk[i] = 0; end
    do_reset();
    check("reset_len", frame_len, 0);
    check("reset_valid", frame_valid, 0);
    check("reset_data_nonzero", frame_data != '0, 0);
    check("reset_pulses", {in_request, transmit_ack, interrupt, p_error, chunk_done}, 0);

    // interrupt packet
    send_token(8'hE1, 7'h15);
    send_data(8'hC3, 8'h04, 2, -1, 0);

    // two-packet frame, with a repeated DATA0 in between
    do_reset();
    send_token(8'hE1, 7'h15); send_data(8'hC3, 8'h01, 65, -1, 0);
    send_token(8'hE1, 7'h15); send_data(8'hC3, 8'h01, 65, -1, 0);
    check("toggle_still_data1", m_tog, 1);
    send_token(8'hE1, 7'h15); send_data(8'h4B, 8'h03, 51, -1, 0);
    check("frame_len_112", frame_len, 112);
    check("chunk0_once", mon_chunk[0], 1);

    // hash while frame held is dropped silently; interrupt still accepted
    send_token(8'hE1, 7'h15); send_data(cur_pid(), 8'h02, 12, -1, 0);
    send_token(8'hE1, 7'h15); send_data(cur_pid(), 8'h04, 2, -1, 0);
    do_ack();

    // wrong address, then a data packet landing in IDLE, then IN token
    send_token(8'hE1, 7'h16);
    send_byte(8'hC3); send_byte(8'h01); send_byte(8'h55); send_eop(0);
    check_state("idle_junk");
    send_token(8'h69, 7'h15);

    // receiver error mid-payload restores the length
    send_token(8'hE1, 7'h15); send_data(cur_pid(), 8'h01, 22, -1, 0);
    send_token(8'hE1, 7'h15); send_data(cur_pid(), 8'h02, 30, 10, 0);
    send_token(8'hE1, 7'h15); send_data(cur_pid(), 8'h02, 7, -1, 0);

    // protocol errors
    send_token(8'hE1, 7'h15); push_exp(P_ERR); send_byte(8'hA5); send_eop(0);
    send_token(8'hE1, 7'h15); send_byte(cur_pid()); push_exp(P_ERR); send_byte(8'h07); send_eop(0);
    send_byte(8'hE1); push_exp(P_ERR); send_eop(0);
    send_token(8'hE1, 7'h15); send_data(cur_pid(), 8'h02, 1, -1, 0);
    check_state("errors");

    // overflow by one byte
    send_token(8'hE1, 7'h15); send_data(cur_pid(), 8'h01, TOTAL + 3, -1, 0);
    check("overflow_len", frame_len, 0);

    // HASH_END eop with frame_ack in the same cycle
    send_token(8'hE1, 7'h15); send_data(cur_pid(), 8'h03, 6, -1, 1);
    check("set_wins_valid", frame_valid, 1);
    do_ack();

    // randomized traffic
    for (int it = 0; it < 25; it++) begin
      logic [7:0] pid, meta;
      int nb, ea;
      pid  = ($urandom_range(0, 3) == 0) ? ~cur_pid() & 8'hCF | 8'h0B : cur_pid();
      pid  = (pid == 8'hC3 || pid == 8'h4B) ? pid : (m_tog ? 8'hC3 : 8'h4B);
      meta = 8'($urandom_range(1, 4));
      nb   = $urandom_range(0, 40);
      ea   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 20) : -1;
      send_token(8'hE1, 7'h15);
      send_data(pid, meta, nb, ea, 0);
      if ($urandom_range(0, 3) == 0) do_ack();
    end

    repeat (4) tick();
    check("scoreboard_empty", exp_q.size(), 0);
    for (int i = 0; i < NC; i++) check("chunk_count", mon_chunk[i], m_chunk[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
